// File: rtl/int8_mm_pkg.sv
// Shared types and lane conversion for the int8 rank-1 matrix multiplier.
// Build option SAT_EN selects saturating (defined) or wrapping (undefined) output conversion.
package int8_mm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int LANES = 8;
  localparam int IN_W  = 8;

  // Caller sign-extends the accumulator to 64 bits and keeps the low out_w bits of the result.
  function automatic logic [63:0] sat_trunc(input logic signed [63:0] acc, input int out_w);
`ifdef SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (acc > hi) begin
      return hi;
    end else if (acc < lo) begin
      return lo;
    end else begin
      return acc;
    end
`else
    return acc & ((64'd1 << out_w) - 64'd1);
`endif
  endfunction

endpackage

// File: rtl/int8_rank1_mm_wrapper_if.sv
// A/B input streams and C output stream of the int8 rank-1 matrix multiplier.
// The slave modport is the multiplier side; master is the producer/consumer side.
interface int8_rank1_mm_wrapper_if #(
  parameter int OUT_W = 16
);
  logic [63:0]        a_tdata;
  logic               a_tvalid;
  logic               a_tready;
  logic [63:0]        b_tdata;
  logic               b_tvalid;
  logic               b_tready;
  logic [8*OUT_W-1:0] c_tdata;
  logic               c_tvalid;
  logic               c_tready;
  logic               c_tlast;

  modport master (
    output a_tdata, a_tvalid, b_tdata, b_tvalid, c_tready,
    input  a_tready, b_tready, c_tdata, c_tvalid, c_tlast
  );

  modport slave (
    input  a_tdata, a_tvalid, b_tdata, b_tvalid, c_tready,
    output a_tready, b_tready, c_tdata, c_tvalid, c_tlast
  );
endinterface

// File: rtl/int8_rank1_acc8x8.sv
// 8x8 array of ACC_W accumulators: one rank-1 update (a_col x b_row) per enabled cycle,
// result visible next cycle; row_o is a combinational view of the selected row.
module int8_rank1_acc8x8
  import int8_mm_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic [LANES*IN_W-1:0]  a_col_i,
  input  logic [LANES*IN_W-1:0]  b_row_i,
  input  logic [2:0]             row_sel_i,
  output logic [LANES*OUT_W-1:0] row_o
);
  logic [ACC_W-1:0]        acc_q [LANES][LANES];
  logic [ACC_W-1:0]        acc_d [LANES][LANES];
  logic signed [2*IN_W-1:0] prod [LANES][LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        prod[i][j] = $signed(a_col_i[i*IN_W +: IN_W]) * $signed(b_row_i[j*IN_W +: IN_W]);
        if (clr_i) begin
          acc_d[i][j] = '0;
        end else if (en_i) begin
          // Product is exact in 16 bits; sign-extend then wrap at ACC_W.
          acc_d[i][j] = acc_q[i][j] + ACC_W'(prod[i][j]);
        end else begin
          acc_d[i][j] = acc_q[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        for (int j = 0; j < LANES; j++) begin
          acc_q[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        for (int j = 0; j < LANES; j++) begin
          acc_q[i][j] <= acc_d[i][j];
        end
      end
    end
  end

  always_comb begin
    row_o = '0;
    for (int j = 0; j < LANES; j++) begin
      row_o[j*OUT_W +: OUT_W] = OUT_W'(sat_trunc(64'(signed'(acc_q[row_sel_i][j])), OUT_W));
    end
  end

endmodule

// File: rtl/int8_rank1_mm_wrapper.sv
// int8 C=A*B (8x8, runtime depth up to K_MAX) behind ap_ctrl; row 0 one cycle after last beat,
// C rows held under c_tready backpressure. Define SAT_EN to saturate output lanes instead of wrapping.
module int8_rank1_mm_wrapper
  import int8_mm_pkg::*;
#(
  parameter int K_MAX = 64,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       ap_ce,
  input  logic                       ap_start,
  output logic                       ap_ready,
  output logic                       ap_idle,
  output logic                       ap_done,
  input  logic                       ap_continue,
  input  logic [$clog2(K_MAX+1)-1:0] k_len,
  int8_rank1_mm_wrapper_if.slave     axis
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam logic [KW-1:0] KEFF_MAX = KW'(K_MAX);

  state_e                 state_q, state_d;
  logic [KW-1:0]          keff_q, keff_d;
  logic [KW-1:0]          beat_q, beat_d;
  logic [2:0]             row_q, row_d;
  logic [KW-1:0]          keff_in;
  logic                   acc_clr;
  logic                   acc_en;
  logic                   c_vld;
  logic                   c_last;
  logic [LANES*OUT_W-1:0] row_dat;

  assign keff_in = (k_len > KEFF_MAX) ? KEFF_MAX : k_len;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      keff_q  <= '0;
      beat_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      keff_q  <= keff_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
    end
  end

  // Every transition is qualified by ap_ce, so a low ap_ce freezes all state.
  always_comb begin
    state_d  = state_q;
    keff_d   = keff_q;
    beat_d   = beat_q;
    row_d    = row_q;
    ap_ready = 1'b0;
    ap_idle  = 1'b0;
    ap_done  = 1'b0;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    c_vld    = 1'b0;
    c_last   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start && ap_ce) begin
          ap_ready = 1'b1;
          acc_clr  = 1'b1;
          keff_d   = keff_in;
          beat_d   = '0;
          row_d    = '0;
          state_d  = (keff_in == '0) ? DRAIN : ACC;
        end
      end
      ACC: begin
        // Joint handshake: a lone valid on either stream is never acknowledged.
        if (axis.a_tvalid && axis.b_tvalid && ap_ce) begin
          acc_en = 1'b1;
          beat_d = beat_q + KW'(1);
          if (beat_q == keff_q - KW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        c_vld  = 1'b1;
        c_last = (row_q == 3'd7);
        if (axis.c_tready && ap_ce) begin
          row_d = row_q + 3'd1;
          if (row_q == 3'd7) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        ap_done = 1'b1;
        if (ap_continue && ap_ce) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign axis.a_tready = acc_en;
  assign axis.b_tready = acc_en;
  assign axis.c_tvalid = c_vld;
  assign axis.c_tlast  = c_last;
  assign axis.c_tdata  = (state_q == DRAIN) ? row_dat : '0;

  int8_rank1_acc8x8 #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_W)
  ) u_acc (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .clr_i     (acc_clr),
    .en_i      (acc_en),
    .a_col_i   (axis.a_tdata),
    .b_row_i   (axis.b_tdata),
    .row_sel_i (row_q),
    .row_o     (row_dat)
  );

endmodule

// File: tb/tb_int8_rank1_mm_wrapper.sv
// Directed bench for int8_rank1_mm_wrapper with a row scoreboard fed by an independent matrix model.
module tb_int8_rank1_mm_wrapper;
  localparam int K_MAX = 64;
  localparam int OUT_W = 16;
  localparam int KW    = 7;

  logic          ap_clk;
  logic          ap_rst_n;
  logic          ap_ce;
  logic          ap_start;
  logic          ap_ready;
  logic          ap_idle;
  logic          ap_done;
  logic          ap_continue;
  logic [KW-1:0] k_len;

  int8_rank1_mm_wrapper_if #(.OUT_W(OUT_W)) axis ();

  int8_rank1_mm_wrapper #(
    .K_MAX(K_MAX),
    .ACC_W(32),
    .OUT_W(OUT_W)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_ce       (ap_ce),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .k_len       (k_len),
    .axis        (axis)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0]  a_beats[$];
  logic [63:0]  b_beats[$];
  logic [127:0] exp_q[$];
  logic         exp_last_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Golden model: C[i][j] = sum_k A[i][k]*B[k][j] in 32-bit wrap, then lane conversion.
  function automatic void push_expected(input int keff);
    logic [127:0]      row;
    logic signed [7:0] ea;
    logic signed [7:0] eb;
    int                s;
    int                v;
    for (int i = 0; i < 8; i++) begin
      row = '0;
      for (int j = 0; j < 8; j++) begin
        s = 0;
        for (int k = 0; k < keff; k++) begin
          ea = a_beats[k][i*8 +: 8];
          eb = b_beats[k][j*8 +: 8];
          s += int'(ea) * int'(eb);
        end
`ifdef SAT_EN
        v = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
`else
        v = s;
`endif
        row[j*16 +: 16] = v[15:0];
      end
      exp_q.push_back(row);
      exp_last_q.push_back(i == 7);
    end
  endfunction

  task automatic run_job(input int klen, input int vpct, input int rpct, input int hold,
                         input bit cont_early);
    int           keff;
    int           idx;
    int           consumed;
    int           avail;
    bit           av;
    bit           bv;
    bit           stall;
    bit           exp_cv;
    bit           done_seen;
    logic [127:0] prev;
    logic [127:0] er;
    logic         el;
    keff      = (klen > K_MAX) ? K_MAX : klen;
    avail     = a_beats.size();
    idx       = 0;
    consumed  = 0;
    av        = 1'b0;
    bv        = 1'b0;
    stall     = 1'b0;
    done_seen = 1'b0;
    prev      = '0;
    exp_cv    = (keff == 0);
    push_expected(keff);
    @(posedge ap_clk); #1;
    ap_start    = 1'b1;
    k_len       = KW'(klen);
    ap_continue = cont_early;
    #1;
    check("ap_ready_on_start", ap_ready, 1'b1);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!av && idx < avail) av = ($urandom_range(99) < vpct);
      if (!bv && idx < avail) bv = ($urandom_range(99) < vpct);
      axis.a_tvalid = av;
      axis.b_tvalid = bv;
      if (idx < avail) begin
        axis.a_tdata = a_beats[idx];
        axis.b_tdata = b_beats[idx];
      end
      axis.c_tready = ($urandom_range(99) < rpct);
      #1;
      if (cyc == 0) begin
        check("ap_ready_single_cycle", ap_ready, 1'b0);
        if (keff > 0 && av && bv) check("tready_after_start", {axis.a_tready, axis.b_tready}, 2'b11);
      end
      if (exp_cv) check("c_tvalid_latency", axis.c_tvalid, 1'b1);
      exp_cv = 1'b0;
      if (av != bv) check("lone_valid_no_tready", {axis.a_tready, axis.b_tready}, 2'b00);
      if (stall) begin
        check("c_tvalid_held", axis.c_tvalid, 1'b1);
        check("c_tdata_stable", axis.c_tdata, prev);
      end
      stall = 1'b0;
      if (axis.c_tvalid) begin
        if (axis.c_tready) begin
          if (exp_q.size() == 0) begin
            check("c_extra_row", axis.c_tvalid, 1'b0);
          end else begin
            er = exp_q.pop_front();
            el = exp_last_q.pop_front();
            check("c_tdata_row", axis.c_tdata, er);
            check("c_tlast_row", axis.c_tlast, el);
          end
        end else begin
          stall = 1'b1;
          prev  = axis.c_tdata;
        end
      end
      if (av && bv && axis.a_tready && axis.b_tready) begin
        consumed++;
        idx++;
        av = 1'b0;
        bv = 1'b0;
        if (consumed == keff) exp_cv = 1'b1;
      end
      if (ap_done) begin
        done_seen = 1'b1;
        break;
      end
      @(posedge ap_clk); #1;
    end
    if (!done_seen) check("done_in_budget", ap_done, 1'b1);
    if (cont_early) begin
      @(posedge ap_clk); #2;
      check("done_one_cycle", {ap_done, ap_idle}, 2'b01);
    end else begin
      repeat (hold) begin
        @(posedge ap_clk); #2;
        check("done_held", ap_done, 1'b1);
      end
      ap_continue = 1'b1;
      @(posedge ap_clk); #1;
      ap_continue = 1'b0;
      #1;
      check("idle_after_continue", {ap_done, ap_idle}, 2'b01);
    end
    ap_continue = 1'b0;
    if (av && bv) check("pending_not_acked", {axis.a_tready, axis.b_tready}, 2'b00);
    check("beats_consumed", consumed, keff);
    check("rows_outstanding", exp_q.size(), 0);
    axis.a_tvalid = 1'b0;
    axis.b_tvalid = 1'b0;
    axis.c_tready = 1'b0;
  endtask

  task automatic fill_random(input int n);
    a_beats.delete();
    b_beats.delete();
    for (int k = 0; k < n; k++) begin
      a_beats.push_back({$urandom(), $urandom()});
      b_beats.push_back({$urandom(), $urandom()});
    end
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] b;
    ap_rst_n      = 1'b0;
    ap_ce         = 1'b1;
    ap_start      = 1'b0;
    ap_continue   = 1'b0;
    k_len         = '0;
    axis.a_tdata  = '0;
    axis.a_tvalid = 1'b0;
    axis.b_tdata  = '0;
    axis.b_tvalid = 1'b0;
    axis.c_tready = 1'b0;
    repeat (2) @(posedge ap_clk);
    #2;
    check("rst_ctrl", {ap_idle, ap_ready, ap_done}, 3'b100);
    check("rst_stream", {axis.a_tready, axis.b_tready, axis.c_tvalid, axis.c_tlast}, 4'b0000);
    check("rst_c_tdata", axis.c_tdata, '0);
    ap_rst_n = 1'b1;

    // Identity A, B[k][j] = 8k+j.
    a_beats.delete();
    b_beats.delete();
    for (int k = 0; k < 8; k++) begin
      a = '0;
      a[k*8 +: 8] = 8'd1;
      for (int j = 0; j < 8; j++) b[j*8 +: 8] = 8'(8 * k + j);
      a_beats.push_back(a);
      b_beats.push_back(b);
    end
    run_job(8, 100, 100, 3, 1'b0);

    // All -128 over 64 beats: true sum 1,048,576 per lane.
    a_beats.delete();
    b_beats.delete();
    for (int k = 0; k < 64; k++) begin
      a_beats.push_back({8{8'h80}});
      b_beats.push_back({8{8'h80}});
    end
    run_job(64, 100, 100, 0, 1'b0);

    // Zero depth with inputs offered: must drain zeros and never take a beat.
    fill_random(4);
    run_job(0, 100, 100, 0, 1'b1);

    // Skewed valids and 50% backpressure.
    fill_random(20);
    run_job(20, 50, 50, 1, 1'b0);

    // Depth clamp: 65 beats offered, 64 consumed.
    fill_random(65);
    run_job(100, 100, 70, 0, 1'b0);

    // Async reset mid-job after three beats.
    fill_random(16);
    @(posedge ap_clk); #1;
    ap_start = 1'b1;
    k_len    = KW'(16);
    @(posedge ap_clk); #1;
    ap_start      = 1'b0;
    axis.a_tvalid = 1'b1;
    axis.b_tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      axis.a_tdata = a_beats[k];
      axis.b_tdata = b_beats[k];
      if (k < 3) begin
        @(posedge ap_clk); #1;
      end
    end
    #1;
    check("pre_reset_tready", {axis.a_tready, axis.b_tready}, 2'b11);
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {ap_idle, ap_ready, ap_done}, 3'b100);
    check("mid_rst_stream", {axis.a_tready, axis.b_tready, axis.c_tvalid, axis.c_tlast}, 4'b0000);
    check("mid_rst_c_tdata", axis.c_tdata, '0);
    axis.a_tvalid = 1'b0;
    axis.b_tvalid = 1'b0;
    @(posedge ap_clk); #2;
    ap_rst_n = 1'b1;
    fill_random(4);
    run_job(4, 60, 50, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/int8_rank1_mm_wrapper.md
# int8_rank1_mm_wrapper

Parametrised int8 matrix-multiply wrapper that computes an 8×8 result C = A·B with a shared dimension K chosen at run time, up to K_MAX. It consumes A column-wise and B row-wise as paired AXI-Stream beats and applies one rank-1 update per beat. It then drains C row by row with backpressure and a last-row marker. It sits behind the same HLS block-level control handshake as the existing 8×8 tensor-slice wrapper and replaces it wherever K > 8 or a runtime depth is needed.

## Interface
- K_MAX, 64: maximum shared dimension (beats per job); ≥1
- ACC_W, 32: accumulator width per element; must satisfy ACC_W ≥ 16 + clog2(K_MAX)
- OUT_W, 16: output lane width; OUT_W ≤ ACC_W
- ap_clk  in  1  clock; one clock domain
- ap_rst_n  in  1  reset, asynchronous, active-low
- ap_ce  in  1  global enable; low freezes all state and forces a_tready = b_tready = 0
- ap_start  in  1  start request
- ap_ready  out  1  high for the single cycle in which a start is accepted
- ap_idle  out  1  high in IDLE
- ap_done  out  1  high in DONE
- ap_continue  in  1  releases DONE
- k_len  in  clog2(K_MAX+1)  job depth; sampled when a start is accepted
- a_tdata  in  64  column k of A: a_tdata[i*8+:8] = A[i][k], signed
- a_tvalid / a_tready  in / out  1
- b_tdata  in  64  row k of B: b_tdata[j*8+:8] = B[k][j], signed
- b_tvalid / b_tready  in / out  1
- c_tdata  out  8*OUT_W  row i of C: c_tdata[j*OUT_W+:OUT_W] = C[i][j]
- c_tvalid / c_tready  out / in  1
- c_tlast  out  1  high on row 7

## Operation
- States: IDLE → ACC → DRAIN → DONE → IDLE.
- **IDLE**
  - When ap_start & ap_ce: ap_ready pulses.
  - Latch keff = min(k_len, K_MAX).
  - Clear all 64 accumulators and the beat and row counters.
  - Go to ACC if keff > 0, otherwise go directly to DRAIN.
- **ACC**
  - Joint handshake: a_tready = b_tready = a_tvalid & b_tvalid & ap_ce.
  - A beat is consumed only when both streams are valid; a lone valid is never acknowledged.
  - Per consumed beat: acc[i][j] += sext(A[i][k] × B[k][j]). Each product is a signed 8×8 → 16-bit value, sign-extended to ACC_W and accumulated modulo 2^ACC_W.
  - When beat keff−1 is consumed, go to DRAIN.
  - No further beats are accepted until the next job; extra input stays pending upstream.
- **DRAIN**
  - c_tvalid = 1; c_tdata is row r of the converted accumulators; c_tlast = (r == 7).
  - r advances on c_tvalid & c_tready.
  - Handshake on row 7 → DONE.
- **DONE**
  - ap_done = 1; stay until ap_continue, then go to IDLE.
  - If ap_continue is already high, DONE lasts exactly one cycle.
- **Conversion** of accumulator to OUT_W: see Configuration.
- ap_start is ignored outside IDLE.

## Timing
- Reset values: ap_idle 1; ap_ready, ap_done, a_tready, b_tready, c_tvalid, c_tlast all 0; c_tdata 0; accumulators 0; state IDLE.
- Reset is asynchronous: assertion mid-job clears everything immediately. The partial job is abandoned and no C beat is emitted.
- ap_start accepted at edge t → a_tready can be high from cycle t+1.
- Last beat accepted at edge t → c_tvalid = 1 with row 0 in cycle t+1, i.e. the row-0 C beat is presented one cycle after the last input beat.
- keff = 0: c_tvalid is high in the cycle after the start is accepted.
- Throughput: one A/B beat per cycle; one C row per cycle when c_tready stays high. Minimum job length is keff + 8 + 2 cycles.
- c_tdata and c_tlast are stable while c_tvalid & !c_tready.
- c_tvalid never drops before its handshake.
- ap_ce low holds all outputs at their current values; handshakes on both sides are suppressed.

## Configuration
- SAT_EN defined: each lane saturates to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- SAT_EN undefined: each lane is the low OUT_W bits of the accumulator (two's-complement wrap).
- Accumulation itself always wraps at ACC_W.

## Structure
- Package int8_mm_pkg:
  - state enum (IDLE, ACC, DRAIN, DONE)
  - LANES = 8, IN_W = 8
  - function sat_trunc(acc, OUT_W), which selects between the two conversions under SAT_EN
- Sub-module int8_rank1_acc8x8:
  - 64 ACC_W accumulators with clear and enable
  - a_col and b_row inputs
  - row-select output of 8 converted lanes
- The wrapper holds the FSM, the counters and the handshakes.

## Test plan
- Identity: k_len=8, A=I, B[k][j]=8k+j → C row i = {8i+7..8i}; c_tlast only on row 7; ap_done high until ap_continue.
- Saturation: k_len=64, all A and B elements −128 → each true sum is 1,048,576. With SAT_EN every lane = 0x7FFF; without SAT_EN every lane = 0x0000.
- k_len=0: start → eight all-zero C rows; a_tready and b_tready never assert.
- Skew and backpressure: random a_tvalid/b_tvalid skew and c_tready at 50% → results match the golden model. No tready while only one side is valid; c_tdata stable under stall.
- Clamp: K_MAX=64, k_len=100 → exactly 64 beats consumed; the 65th pending beat is not acknowledged before the next start.
- Async reset after 3 of 16 beats → outputs at reset values within the cycle. The following job with k_len=4 produces correct C.
